// File: rtl/regwb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   WB_WIDTH / WB_ADDR : register data and address widths (mirrors project_defs.vh)
//   REG_ZERO           : hard-wired zero register; writes to it are suppressed
//   wb_req_t           : one writeback request {addr, data}
package regwb_pkg;

    localparam int unsigned WB_WIDTH = 64;
    localparam int unsigned WB_ADDR  = 5;

    localparam logic [WB_ADDR-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_ADDR-1:0]  addr;
        logic [WB_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot picker with its own pointer register.
// The search starts at the pointer and wraps; after a grant to i the
// pointer moves to i+1 so the winner becomes lowest priority.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, pointer -> 0
//   en_i    : allow a grant this cycle (low forces grant_o = 0, pointer frozen)
//   valid_i : per-requester request
//   grant_o : one-hot grant, combinational
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [N-1:0] valid_i,
    output logic [N-1:0] grant_o
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] sel;
    logic          found;
    int unsigned   idx;

    always_comb begin
        grant_o = '0;
        sel     = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && valid_i[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
        if (found && en_i) begin
            grant_o[sel] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|grant_o) begin
            ptr_d = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regwb_arbiter.sv
// Writeback arbiter for the single write port of the register file.
// NREQ sources share the port round-robin via valid/ready; the winner is
// registered into an output stage that drives p_we/p_writeaddr/p_din.
// Writes to r0 complete the handshake but never raise p_we.
// Optional feature (macro REGWB_FWD_EN): two forwarding read ports that
// expose the in-flight write so readers see it in the same cycle.
//   p_clk, p_rst     : clock, synchronous active-high reset
//   p_hold           : pipeline hold, blocks all grants
//   p_req_valid      : per-requester request
//   p_req_addr/data  : packed per-requester address/data
//   p_req_ready      : one-hot grant
//   p_we/p_writeaddr/p_din : registered register-file write port
//   p_fwd_*          : forwarding ports (REGWB_FWD_EN only)
module regwb_arbiter
    import regwb_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned WIDTH = WB_WIDTH,
    parameter int unsigned ADDR  = WB_ADDR
) (
    input  logic                  p_clk,
    input  logic                  p_rst,
    input  logic                  p_hold,
    input  logic [NREQ-1:0]       p_req_valid,
    input  logic [NREQ*ADDR-1:0]  p_req_addr,
    input  logic [NREQ*WIDTH-1:0] p_req_data,
    output logic [NREQ-1:0]       p_req_ready,
`ifdef REGWB_FWD_EN
    input  logic [ADDR-1:0]       p_fwd_raddr1,
    input  logic [ADDR-1:0]       p_fwd_raddr2,
    output logic                  p_fwd_hit1,
    output logic                  p_fwd_hit2,
    output logic [WIDTH-1:0]      p_fwd_data1,
    output logic [WIDTH-1:0]      p_fwd_data2,
`endif
    output logic                  p_we,
    output logic [ADDR-1:0]       p_writeaddr,
    output logic [WIDTH-1:0]      p_din
);

    logic [NREQ-1:0]  gnt;
    logic             xfer;
    wb_req_t          gnt_req;

    logic             we_q, we_d;
    logic [ADDR-1:0]  waddr_q, waddr_d;
    logic [WIDTH-1:0] din_q, din_d;

    // Reset also blocks grants so nothing handshakes while the stage is cleared.
    rr_arbiter #(
        .N(NREQ)
    ) u_rr_arbiter (
        .clk_i   (p_clk),
        .rst_i   (p_rst),
        .en_i    (!p_hold && !p_rst),
        .valid_i (p_req_valid),
        .grant_o (gnt)
    );

    assign p_req_ready = gnt;
    assign xfer        = |gnt;

    // One-hot grant, so an OR-style mux is enough.
    always_comb begin
        gnt_req = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_req.addr = p_req_addr[i*ADDR +: ADDR];
                gnt_req.data = p_req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        din_d   = din_q;
        if (xfer) begin
            we_d    = (gnt_req.addr != REG_ZERO);
            waddr_d = gnt_req.addr;
            din_d   = gnt_req.data;
        end
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
        end
    end

    assign p_we        = we_q;
    assign p_writeaddr = waddr_q;
    assign p_din       = din_q;

`ifdef REGWB_FWD_EN
    // we_q is never set for r0, so no separate zero-register check here.
    assign p_fwd_hit1  = we_q && (waddr_q == p_fwd_raddr1);
    assign p_fwd_hit2  = we_q && (waddr_q == p_fwd_raddr2);
    assign p_fwd_data1 = din_q;
    assign p_fwd_data2 = din_q;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Scoreboard bench for regwb_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever p_we is high.
module tb_regwb_arbiter;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned ADDR  = 5;

    logic                  p_clk = 1'b0;
    logic                  p_rst;
    logic                  p_hold;
    logic [NREQ-1:0]       p_req_valid;
    logic [NREQ*ADDR-1:0]  p_req_addr;
    logic [NREQ*WIDTH-1:0] p_req_data;
    logic [NREQ-1:0]       p_req_ready;
    logic                  p_we;
    logic [ADDR-1:0]       p_writeaddr;
    logic [WIDTH-1:0]      p_din;
`ifdef REGWB_FWD_EN
    logic [ADDR-1:0]       p_fwd_raddr1;
    logic [ADDR-1:0]       p_fwd_raddr2;
    logic                  p_fwd_hit1;
    logic                  p_fwd_hit2;
    logic [WIDTH-1:0]      p_fwd_data1;
    logic [WIDTH-1:0]      p_fwd_data2;
`endif

    logic [ADDR-1:0]  a [NREQ];
    logic [WIDTH-1:0] d [NREQ];

    always_comb begin
        p_req_addr = '0;
        p_req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_req_addr[i*ADDR +: ADDR]   = a[i];
            p_req_data[i*WIDTH +: WIDTH] = d[i];
        end
    end

    always #5 p_clk = ~p_clk;

    regwb_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .ADDR  (ADDR)
    ) dut (
        .p_clk       (p_clk),
        .p_rst       (p_rst),
        .p_hold      (p_hold),
        .p_req_valid (p_req_valid),
        .p_req_addr  (p_req_addr),
        .p_req_data  (p_req_data),
        .p_req_ready (p_req_ready),
`ifdef REGWB_FWD_EN
        .p_fwd_raddr1(p_fwd_raddr1),
        .p_fwd_raddr2(p_fwd_raddr2),
        .p_fwd_hit1  (p_fwd_hit1),
        .p_fwd_hit2  (p_fwd_hit2),
        .p_fwd_data1 (p_fwd_data1),
        .p_fwd_data2 (p_fwd_data2),
`endif
        .p_we        (p_we),
        .p_writeaddr (p_writeaddr),
        .p_din       (p_din)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [ADDR-1:0]  addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge p_clk);
        #1;
    endtask

    task automatic expect_ready(input string name, input logic [NREQ-1:0] exp);
        #1;
        check(name, WIDTH'(p_req_ready), WIDTH'(exp));
    endtask

    task automatic push(input logic [ADDR-1:0] addr, input logic [WIDTH-1:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Monitor: every committed write must match the oldest expected one.
    always @(negedge p_clk) begin
        if (p_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t",
                         p_writeaddr, p_din, $time);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", WIDTH'(p_writeaddr), WIDTH'(w.addr));
                check("wr_data", p_din, w.data);
            end
        end
    end

    initial begin
        int g;
        p_rst       = 1'b1;
        p_hold      = 1'b0;
        p_req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
`ifdef REGWB_FWD_EN
        p_fwd_raddr1 = '0;
        p_fwd_raddr2 = '0;
`endif
        step();
        step();
        // Reset state, and no grant while reset is high even with requests.
        p_req_valid = 3'b111;
        expect_ready("ready_in_reset", 3'b000);
        check("rst_we", WIDTH'(p_we), '0);
        check("rst_waddr", WIDTH'(p_writeaddr), '0);
        check("rst_din", p_din, '0);
        p_req_valid = '0;

        // Single request from requester 1.
        p_rst = 1'b0;
        step();
        a[1] = 5'd5;
        d[1] = 64'hDEAD_BEEF;
        p_req_valid = 3'b010;
        expect_ready("single_ready", 3'b010);
        push(5'd5, 64'hDEAD_BEEF);
        step();
        p_req_valid = '0;
        p_rst = 1'b1;
        step();

        // Round-robin with all three valid from reset.
        p_rst = 1'b0;
        a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
        d[0] = 64'h10; d[1] = 64'h20; d[2] = 64'h30;
        p_req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            g = k % 3;
            expect_ready("rr_ready", 3'(1 << g));
            push(a[g], d[g]);
            step();
            d[g] = d[g] + 64'h1000;
        end
        p_req_valid = '0;

        // r0 write: handshake completes, no p_we, pointer moves to 1.
        a[0] = 5'd0;
        d[0] = 64'h1;
        p_req_valid = 3'b001;
        expect_ready("r0_ready", 3'b001);
        step();
        a[0] = 5'd4; d[0] = 64'h44;
        a[1] = 5'd6; d[1] = 64'h66;
        p_req_valid = 3'b011;
        expect_ready("r0_ptr_adv", 3'b010);
        push(5'd6, 64'h66);
        step();
        p_req_valid = 3'b001;
        expect_ready("rr_wrap", 3'b001);
        push(5'd4, 64'h44);
        step();
        p_req_valid = '0;

        // Hold for three cycles: no grant; release grants 2 at once.
        p_hold = 1'b1;
        a[2] = 5'd9; d[2] = 64'h99;
        p_req_valid = 3'b100;
        for (int k = 0; k < 3; k++) begin
            expect_ready("hold_ready", 3'b000);
            step();
        end
        p_hold = 1'b0;
        expect_ready("hold_release", 3'b100);
        push(5'd9, 64'h99);
        step();
        p_req_valid = '0;

        // Reset mid-stream; pointer would be 1, reset returns it to 0.
        a[0] = 5'd11; d[0] = 64'hB1;
        a[1] = 5'd12; d[1] = 64'hC1;
        p_req_valid = 3'b011;
        expect_ready("pre_rst_ready", 3'b001);
        push(5'd11, 64'hB1);
        step();
        d[0] = 64'hB2;
        p_rst = 1'b1;
        expect_ready("mid_rst_ready", 3'b000);
        step();
        p_rst = 1'b0;
        check("post_rst_we", WIDTH'(p_we), '0);
        expect_ready("post_rst_ptr0", 3'b001);
        push(5'd11, 64'hB2);
        step();
        p_req_valid = '0;

`ifdef REGWB_FWD_EN
        a[1] = 5'd7; d[1] = 64'd42;
        p_fwd_raddr1 = 5'd7;
        p_fwd_raddr2 = 5'd8;
        p_req_valid = 3'b010;
        expect_ready("fwd_ready", 3'b010);
        push(5'd7, 64'd42);
        step();
        p_req_valid = '0;
        check("fwd_hit1", WIDTH'(p_fwd_hit1), 64'd1);
        check("fwd_data1", p_fwd_data1, 64'd42);
        check("fwd_hit2", WIDTH'(p_fwd_hit2), 64'd0);
`endif

        step();
        step();
        check("queue_drained", WIDTH'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regwb_arbiter.md
Name: regwb_arbiter

Overview:
- Writeback arbiter for the single write port of the 64-bit register file.
- Shares that port between NREQ writeback sources (ALU, load unit, mult/div) using round-robin arbitration and a valid/ready handshake.
- Drives the register file's p_we / p_writeaddr / p_din from a registered output stage.
- Suppresses writes to r0.

Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- WIDTH, `WIDTH (64), data width
- ADDR, `ADDR (5), register address width

Ports:
- p_clk  in  1  clock; all logic on posedge
- p_rst  in  1  synchronous reset, active-high
- p_hold  in  1  pipeline hold; while high no grants are issued
- p_req_valid  in  NREQ  per-requester write request
- p_req_addr  in  NREQ*ADDR  packed destination addresses; requester i at [i*ADDR +: ADDR]
- p_req_data  in  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
- p_req_ready  out  NREQ  one-hot grant; combinational from valid, hold and pointer
- p_we  out  1  register file write enable (registered)
- p_writeaddr  out  ADDR  register file write address (registered)
- p_din  out  WIDTH  register file write data (registered)

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - Ports are named p_clk and p_rst.
- Reset values: p_we=0, p_writeaddr=0, p_din=0, round-robin pointer rr_ptr=0.
- While p_rst is high, p_req_ready=0.
- Arbitration (combinational):
  - If p_hold=0, grant the first i with p_req_valid[i]=1, scanning rr_ptr, rr_ptr+1, …, wrapping modulo NREQ.
  - p_req_ready = one-hot of that i, or 0 if there is no valid request or p_hold=1.
- Transfer occurs when p_req_valid[i] & p_req_ready[i].
  - The requester must hold valid/addr/data stable until the transfer; it may not withdraw a request.
- Pointer update:
  - On a transfer by i, rr_ptr <= (i+1) mod NREQ.
  - With no transfer, rr_ptr holds.
- Output stage, on the clock edge after a transfer:
  - p_writeaddr <= granted addr, p_din <= granted data.
  - p_we <= (addr != 0).
  - Total latency from transfer to register file write is 1 cycle; write visible on register file reads 2 edges after transfer.
- No transfer → p_we <= 0; p_writeaddr and p_din hold their last values.
- Throughput: one write per cycle. A requester continuously valid is granted at least once every NREQ cycles.
- Write to r0: handshake completes normally (ready asserted, pointer advances), but p_we stays 0.
- Same address from two requesters in one cycle: only one is granted per cycle. Program ordering between requesters is guaranteed upstream by the hazard unit, not here.
- p_hold asserted during a request: no grant, pointer frozen. A write already in the output stage still commits (p_we as registered).
- Reset mid-operation:
  - The output stage is cleared on that edge; an in-flight write is dropped.
  - Requests held valid across reset are re-arbitrated from rr_ptr=0.

Optional Feature:
- Macro: REGWB_FWD_EN.
- Defined:
  - Adds inputs p_fwd_raddr1 and p_fwd_raddr2 (ADDR each).
  - Adds outputs p_fwd_hit1, p_fwd_hit2 (1) and p_fwd_data1, p_fwd_data2 (WIDTH).
  - p_fwd_hitN = p_we & (p_writeaddr == p_fwd_raddrN); combinational. p_we already excludes r0.
  - p_fwd_dataN = p_din.
  - Hides the same-cycle write/read gap of the register file.
- Undefined: these ports do not exist; all other behaviour is identical.

Decomposition:
- Package regwb_pkg: WIDTH/ADDR constants mirrored from project_defs.vh, REG_ZERO = 0, and a typedef wb_req_t {addr, data}.
- One natural sub-module: rr_arbiter (NREQ-wide rotating-priority one-hot picker plus pointer register).
  - Reused later by the memory-port arbiter.

Test Plan:
- Single request, NREQ=3:
  - Stimulus: req1 addr=5, data=64'hDEAD_BEEF.
  - Response: ready=3'b010 the same cycle; next cycle p_we=1, p_writeaddr=5, p_din=DEAD_BEEF.
- Round-robin:
  - Stimulus: all three valid continuously from reset.
  - Response: grants in order 0,1,2,0,1,2 on consecutive cycles, with p_we high every cycle after the first.
- r0 suppression:
  - Stimulus: req0 addr=0, data=1.
  - Response: ready[0]=1, pointer advances to 1, p_we stays 0.
- Hold:
  - Stimulus: req2 valid with p_hold=1 for 3 cycles.
  - Response: ready=0 and p_we=0 throughout (after any prior write commits); on release, grant 2 in the same cycle.
- Reset mid-stream:
  - Stimulus: assert p_rst in the cycle after req0 is granted.
  - Response: p_we=0 on the next edge (write dropped), rr_ptr=0, ready=0 while reset is high.
- REGWB_FWD_EN:
  - Stimulus: write addr=7, data=42, with p_fwd_raddr1=7 and p_fwd_raddr2=8.
  - Response: in the p_we cycle, hit1=1 with data1=42, and hit2=0.
